// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Two-port request bus plus split low/high byte bank interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
  logic        cpu_req,   dbg_req;
  logic        cpu_we,    dbg_we;
  logic        cpu_byte,  dbg_byte;
  logic [15:0] cpu_addr,  dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_gnt,   dbg_gnt;
  logic        cpu_done,  dbg_done;
  logic [15:0] rdata;
  logic        busy;
  logic [15:0] mem_lb_addr,  mem_ub_addr;
  logic [7:0]  mem_lb_wdata, mem_ub_wdata;
  logic        mem_lb_we,    mem_ub_we;
  logic [7:0]  mem_lb_rdata, mem_ub_rdata;

  modport slave (
    input  cpu_req, dbg_req, cpu_we, dbg_we, cpu_byte, dbg_byte,
    input  cpu_addr, dbg_addr, cpu_wdata, dbg_wdata,
    input  mem_lb_rdata, mem_ub_rdata,
    output cpu_gnt, dbg_gnt, cpu_done, dbg_done, rdata, busy,
    output mem_lb_addr, mem_ub_addr, mem_lb_wdata, mem_ub_wdata,
    output mem_lb_we, mem_ub_we
  );

  modport master (
    output cpu_req, dbg_req, cpu_we, dbg_we, cpu_byte, dbg_byte,
    output cpu_addr, dbg_addr, cpu_wdata, dbg_wdata,
    output mem_lb_rdata, mem_ub_rdata,
    input  cpu_gnt, dbg_gnt, cpu_done, dbg_done, rdata, busy,
    input  mem_lb_addr, mem_ub_addr, mem_lb_wdata, mem_ub_wdata,
    input  mem_lb_we, mem_ub_we
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : CPU/debug arbiter onto split byte-bank memory, CPU priority
//               with a starvation guard for the debug port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input wire           clk,
  input wire           rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] C_STARVE_LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      state_q,   state_d;
  logic        owner_q,   owner_d;
  logic        we_q,      we_d;
  logic        byte_q,    byte_d;
  logic [15:0] lb_addr_q, lb_addr_d;
  logic [15:0] ub_addr_q, ub_addr_d;
  logic [15:0] wdata_q,   wdata_d;
  logic [15:0] rdata_q,   rdata_d;
  logic [2:0]  starve_q,  starve_d;
  logic        w_dbg_wins;
  logic [15:0] w_sel_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      lb_addr_q <= '0;
      ub_addr_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      byte_q    <= byte_d;
      lb_addr_q <= lb_addr_d;
      ub_addr_q <= ub_addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      starve_q  <= starve_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    byte_d     = byte_q;
    lb_addr_d  = lb_addr_q;
    ub_addr_d  = ub_addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    starve_d   = starve_q;
    // Debug wins when alone, or when the CPU has used up its streak.
    w_dbg_wins = bus.dbg_req && (!bus.cpu_req || (starve_q == C_STARVE_LIMIT));
    w_sel_addr = w_dbg_wins ? bus.dbg_addr : bus.cpu_addr;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          owner_d   = w_dbg_wins;
          we_d      = w_dbg_wins ? bus.dbg_we    : bus.cpu_we;
          byte_d    = w_dbg_wins ? bus.dbg_byte  : bus.cpu_byte;
          wdata_d   = w_dbg_wins ? bus.dbg_wdata : bus.cpu_wdata;
          lb_addr_d = w_sel_addr;
          ub_addr_d = w_sel_addr + 16'd1;
          if (w_dbg_wins || !bus.dbg_req) begin
            starve_d = '0;
          end else if (starve_q != 3'd7) begin
            starve_d = starve_q + 3'd1;
          end
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = we_q ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        rdata_d = byte_q ? {8'h00, bus.mem_lb_rdata}
                         : {bus.mem_ub_rdata, bus.mem_lb_rdata};
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs decode from flops so the async reset clears them at once.
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.cpu_gnt      = (state_q == S_ACCESS) && !owner_q;
  assign bus.dbg_gnt      = (state_q == S_ACCESS) &&  owner_q;
  assign bus.cpu_done     = (state_q == S_DONE)   && !owner_q;
  assign bus.dbg_done     = (state_q == S_DONE)   &&  owner_q;
  assign bus.mem_lb_we    = (state_q == S_ACCESS) && we_q;
  assign bus.mem_ub_we    = (state_q == S_ACCESS) && we_q && !byte_q;
  assign bus.mem_lb_addr  = lb_addr_q;
  assign bus.mem_ub_addr  = ub_addr_q;
  assign bus.mem_lb_wdata = wdata_q[7:0];
  assign bus.mem_ub_wdata = wdata_q[15:8];
  assign bus.rdata        = rdata_q;

endmodule

`default_nettype wire
